lcd_display_arbiter: RTL and testbench

//  - Shares the single 16x2 LCD driver between three requesters: alarm (prio 2, highest), UART-RX echo (prio 1), sensor metrics (prio 0).
//  - Latches the winning request's 2x128-bit row data and runs the lcd_en/lcd_done handshake with the LCD driver.
//  - Enforces a per-class minimum on-screen hold time, so a fresh metrics refresh cannot overwrite an RX echo or alarm.
//  - Sits between logic_controller-style producers and the LCD driver; 1 MHz clk.

---
 rtl/lcd_arb_pkg.sv | 32 +++
 rtl/lcd_hold_timer.sv | 29 ++
 rtl/lcd_display_arbiter.sv | 160 ++++++++++++++++
 tb/tb_lcd_display_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_arb_pkg.sv
// Shared types and constants for the LCD display arbiter: FSM states,
// requester indices and the power-on banner text.
package lcd_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  localparam logic [1:0] REQ_METRICS = 2'd0;
  localparam logic [1:0] REQ_RX      = 2'd1;
  localparam logic [1:0] REQ_ALARM   = 2'd2;
  localparam logic [1:0] OWNER_NONE  = 2'd3;

  localparam int ROW_W = 128;
  localparam int N_REQ = 3;

  localparam logic [ROW_W-1:0] BANNER_ROW1 = "  Cold Storage  ";
  localparam logic [ROW_W-1:0] BANNER_ROW2 = "     Welcome    ";

  typedef struct packed {
    logic       valid;
    logic [1:0] idx;
  } pick_t;

  // Width of a counter that must hold 0..max_val, never narrower than 1 bit.
  function automatic int cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/lcd_hold_timer.sv
// Loadable down-counter that saturates at zero; tracks how long the current
// screen owner is still protected from lower-priority replacement.
module lcd_hold_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/lcd_display_arbiter.sv
// Shares one 16x2 LCD driver between alarm, RX-echo and metrics producers,
// with per-class minimum on-screen hold and a write watchdog.
module lcd_display_arbiter
  import lcd_arb_pkg::*;
#(
  parameter int unsigned HOLD_ALARM   = 3_000_000,
  parameter int unsigned HOLD_RX      = 2_000_000,
  parameter int unsigned HOLD_METRICS = 0,
  parameter int unsigned WR_TIMEOUT   = 100_000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       i_req,
  input  logic [N_REQ*ROW_W-1:0] i_row1,
  input  logic [N_REQ*ROW_W-1:0] i_row2,
  output logic [N_REQ-1:0]       o_ack,
  output logic                   o_lcd_en,
  input  logic                   i_lcd_done,
  output logic [ROW_W-1:0]       o_lcd_row1,
  output logic [ROW_W-1:0]       o_lcd_row2,
  output logic [1:0]             o_owner,
  output logic                   o_busy,
  output logic                   o_timeout_err
);

  localparam int unsigned HOLD_MAX_AR = (HOLD_ALARM > HOLD_RX) ? HOLD_ALARM : HOLD_RX;
  localparam int unsigned HOLD_MAX    = (HOLD_MAX_AR > HOLD_METRICS) ? HOLD_MAX_AR : HOLD_METRICS;
  localparam int HW = cnt_width(HOLD_MAX);
  localparam int WW = cnt_width(WR_TIMEOUT);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [N_REQ-1:0] r_ack;
  logic             r_lcd_en;
  logic             r_busy;
  logic             r_timeout_err;
  logic             r_armed;
  logic [1:0]       r_owner;
  logic [ROW_W-1:0] r_row1;
  logic [ROW_W-1:0] r_row2;
  logic [WW-1:0]    r_wd_cnt;

  pick_t            w_pick;
  logic             w_accept;
  logic             w_done;
  logic             w_timeout;
  logic             w_hold_zero;
  logic [HW-1:0]    w_hold_load;

  // Highest eligible index wins; a lower class than the owner needs an expired hold.
  function automatic pick_t pick_winner(input state_t st, input logic [N_REQ-1:0] req,
                                        input logic [1:0] owner, input logic hold_zero);
    pick_t p;
    p = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (req[i] && ((st == ST_IDLE) || (i >= int'(owner)) || hold_zero)) begin
        p.valid = 1'b1;
        p.idx   = 2'(i);
      end
    end
    return p;
  endfunction

  always_comb begin
    // NOTE: every signal driven here gets a default first so no latch is inferred.
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_done      = 1'b0;
    w_timeout   = 1'b0;
    w_pick      = pick_winner(r_state, i_req, r_owner, w_hold_zero);
    case (r_state)
      ST_IDLE, ST_HOLD: begin
        if (w_pick.valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (r_armed && i_lcd_done) begin
          w_done      = 1'b1;
          w_state_nxt = ST_HOLD;
        end else if (r_wd_cnt == WW'(WR_TIMEOUT - 1)) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_HOLD;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_hold_load = '0;
    case (r_owner)
      REQ_ALARM:   w_hold_load = HW'(HOLD_ALARM);
      REQ_RX:      w_hold_load = HW'(HOLD_RX);
      REQ_METRICS: w_hold_load = HW'(HOLD_METRICS);
      default:     w_hold_load = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // A watchdog expiry reloads zero so any waiting requester can take over at once.
  lcd_hold_timer #(.W(HW)) u_hold_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_done | w_timeout),
    .i_load_val (w_done ? w_hold_load : '0),
    .i_en       (r_state == ST_HOLD),
    .o_zero     (w_hold_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack         <= '0;
      r_lcd_en      <= 1'b0;
      r_busy        <= 1'b0;
      r_timeout_err <= 1'b0;
      r_armed       <= 1'b0;
      r_owner       <= OWNER_NONE;
      r_row1        <= BANNER_ROW1;
      r_row2        <= BANNER_ROW2;
      r_wd_cnt      <= '0;
    end else begin
      r_ack         <= '0;
      r_timeout_err <= w_timeout;
      if (w_accept) begin
        r_ack[w_pick.idx] <= 1'b1;
        r_owner           <= w_pick.idx;
        r_row1            <= i_row1[w_pick.idx*ROW_W +: ROW_W];
        r_row2            <= i_row2[w_pick.idx*ROW_W +: ROW_W];
        r_lcd_en          <= 1'b1;
        r_busy            <= 1'b1;
        r_armed           <= 1'b0;
        r_wd_cnt          <= '0;
      end
      if (r_state == ST_WRITE) begin
        // A done level left over from the previous frame must drop before it counts.
        if (!i_lcd_done) r_armed <= 1'b1;
        if (!w_timeout)  r_wd_cnt <= r_wd_cnt + WW'(1);
      end
      if (w_done || w_timeout) begin
        r_lcd_en <= 1'b0;
        r_busy   <= 1'b0;
      end
    end
  end

  assign o_ack         = r_ack;
  assign o_lcd_en      = r_lcd_en;
  assign o_busy        = r_busy;
  assign o_timeout_err = r_timeout_err;
  assign o_owner       = r_owner;
  assign o_lcd_row1    = r_row1;
  assign o_lcd_row2    = r_row2;

endmodule

// File: tb/tb_lcd_display_arbiter.sv
// Self-checking bench for lcd_display_arbiter: directed scenarios plus random
// requesters, all outputs compared every cycle against a timestamp-based model.
module tb_lcd_display_arbiter;

  localparam int HOLD_ALARM   = 30;
  localparam int HOLD_RX      = 20;
  localparam int HOLD_METRICS = 0;
  localparam int WR_TIMEOUT   = 50;
  localparam int BOUND        = 300;
  localparam logic [127:0] BAN1 = "  Cold Storage  ";
  localparam logic [127:0] BAN2 = "     Welcome    ";

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [2:0]   r_req = '0;
  logic [383:0] r_row1 = '0;
  logic [383:0] r_row2 = '0;
  logic         lcd_done = 1'b0;
  logic [2:0]   o_ack;
  logic         o_lcd_en;
  logic [127:0] o_lcd_row1;
  logic [127:0] o_lcd_row2;
  logic [1:0]   o_owner;
  logic         o_busy;
  logic         o_timeout_err;

  int n_total = 0;
  int n_bad   = 0;
  int drv_mode = 0;  // 0: done 5 cycles after en, 1: done stuck high, 2: never done
  int drv_cnt  = 0;

  lcd_display_arbiter #(
    .HOLD_ALARM   (HOLD_ALARM),
    .HOLD_RX      (HOLD_RX),
    .HOLD_METRICS (HOLD_METRICS),
    .WR_TIMEOUT   (WR_TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_req         (r_req),
    .i_row1        (r_row1),
    .i_row2        (r_row2),
    .o_ack         (o_ack),
    .o_lcd_en      (o_lcd_en),
    .i_lcd_done    (lcd_done),
    .o_lcd_row1    (o_lcd_row1),
    .o_lcd_row2    (o_lcd_row2),
    .o_owner       (o_owner),
    .o_busy        (o_busy),
    .o_timeout_err (o_timeout_err)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: screen ownership with absolute-cycle deadlines.
  int           hold_tab [3] = '{HOLD_METRICS, HOLD_RX, HOLD_ALARM};
  logic [2:0]   e_ack;
  logic         e_en, e_busy, e_to;
  logic [1:0]   e_owner;
  logic [127:0] e_row1, e_row2;
  bit           m_idle, m_writing, m_armed;
  int           cyc, m_wstart, m_free_at;

  task automatic model_reset();
    e_ack = '0; e_en = 0; e_busy = 0; e_to = 0; e_owner = 2'd3;
    e_row1 = BAN1; e_row2 = BAN2;
    m_idle = 1; m_writing = 0; m_armed = 0;
    cyc = 0; m_wstart = 0; m_free_at = 0;
  endtask

  task automatic model_step();
    int win;
    cyc++;
    e_ack = '0;
    e_to  = 0;
    if (m_writing) begin
      if (m_armed && lcd_done) begin
        m_writing = 0; e_en = 0; e_busy = 0;
        m_free_at = cyc + hold_tab[e_owner] + 1;
      end else if (cyc - m_wstart == WR_TIMEOUT) begin
        m_writing = 0; e_en = 0; e_busy = 0; e_to = 1;
        m_free_at = cyc + 1;
      end
      if (!lcd_done) m_armed = 1;
    end else begin
      win = -1;
      for (int i = 0; i < 3; i++)
        if (r_req[i] && (m_idle || i >= int'(e_owner) || cyc >= m_free_at)) win = i;
      if (win >= 0) begin
        e_ack[win] = 1'b1;
        e_owner    = 2'(win);
        e_row1     = r_row1[128*win +: 128];
        e_row2     = r_row2[128*win +: 128];
        e_en = 1; e_busy = 1;
        m_writing = 1; m_armed = 0; m_wstart = cyc; m_idle = 0;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  initial forever begin
    @(negedge clk);
    check("ack",   128'(o_ack),         128'(e_ack));
    check("en",    128'(o_lcd_en),      128'(e_en));
    check("busy",  128'(o_busy),        128'(e_busy));
    check("tmo",   128'(o_timeout_err), 128'(e_to));
    check("owner", 128'(o_owner),       128'(e_owner));
    check("row1",  o_lcd_row1,          e_row1);
    check("row2",  o_lcd_row2,          e_row2);
  end

  // LCD driver model
  initial forever begin
    @(negedge clk);
    if (drv_mode != 0 || !o_lcd_en) drv_cnt = 0;
    else                            drv_cnt++;
    case (drv_mode)
      1:       lcd_done = 1'b1;
      2:       lcd_done = 1'b0;
      default: lcd_done = (drv_cnt >= 5);
    endcase
  end

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic raise(input int i, input logic [127:0] d1, input logic [127:0] d2);
    r_row1[128*i +: 128] = d1;
    r_row2[128*i +: 128] = d2;
    r_req[i] = 1'b1;
  endtask

  // Waits for an ack pulse and drops the acked request, as a real requester would.
  task automatic wait_ack(output logic [2:0] a, output int n);
    a = '0;
    n = 0;
    while (n < BOUND && a == '0) begin
      @(negedge clk);
      n++;
      if (o_ack != '0) begin
        a = o_ack;
        r_req = r_req & ~o_ack;
      end
    end
    check("ack_seen", 128'(a != '0), 128'(1));
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (o_busy && n < BOUND);
    check("done_seen", 128'(o_busy), 128'(0));
  endtask

  task automatic wait_tmo(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!o_timeout_err && n < BOUND);
    check("tmo_seen", 128'(o_timeout_err), 128'(1));
  endtask

  task automatic rand_drive();
    for (int i = 0; i < 3; i++) begin
      if (r_req[i]) begin
        if (o_ack[i]) r_req[i] = 1'b0;
      end else if ($urandom_range(0, 19) == 0) begin
        raise(i, rnd128(), rnd128());
      end
    end
    if ($urandom_range(0, 249) == 0) drv_mode = int'($urandom_range(0, 2));
  endtask

  initial begin
    logic [2:0] a;
    int n;

    // 1. reset state, then idle with no request
    repeat (3) @(negedge clk);
    check("rst_en",    128'(o_lcd_en), 128'(0));
    check("rst_owner", 128'(o_owner),  128'(3));
    check("rst_row1",  o_lcd_row1,     BAN1);
    check("rst_row2",  o_lcd_row2,     BAN2);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_ack",  128'(o_ack),    128'(0));
    check("idle_busy", 128'(o_busy),   128'(0));

    // 2. single metrics frame
    raise(0, "Temp: 21 C      ", "Hum: 40 %       ");
    wait_ack(a, n);
    check("t2_ack",  128'(a), 128'(3'b001));
    check("t2_lat",  128'(n), 128'(1));
    check("t2_en",   128'(o_lcd_en), 128'(1));
    wait_done(n);
    check("t2_wr_lat", 128'(n), 128'(5));
    check("t2_owner",  128'(o_owner), 128'(0));
    check("t2_row1",   o_lcd_row1, "Temp: 21 C      ");

    // 3. RX hold blocks metrics; alarm preempts immediately
    raise(1, rnd128(), rnd128());
    wait_ack(a, n);
    check("t3_rx_ack", 128'(a), 128'(3'b010));
    wait_done(n);
    repeat (3) @(negedge clk);
    raise(0, rnd128(), rnd128());
    wait_ack(a, n);
    check("t3_met_ack",  128'(a), 128'(3'b001));
    check("t3_hold_lat", 128'(n + 3), 128'(HOLD_RX + 1));
    wait_done(n);
    raise(1, rnd128(), rnd128());
    wait_ack(a, n);
    wait_done(n);
    repeat (3) @(negedge clk);
    raise(2, "ALARM: TEMP HIGH", rnd128());
    wait_ack(a, n);
    check("t3_alarm_ack", 128'(a), 128'(3'b100));
    check("t3_alarm_lat", 128'(n), 128'(1));
    wait_done(n);

    // 4. all three at once from IDLE, then served in priority order
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    raise(0, rnd128(), rnd128());
    raise(1, rnd128(), rnd128());
    raise(2, rnd128(), rnd128());
    wait_ack(a, n);
    check("t4_first", 128'(a), 128'(3'b100));
    wait_done(n);
    wait_ack(a, n);
    check("t4_second", 128'(a), 128'(3'b010));
    check("t4_rx_lat", 128'(n), 128'(HOLD_ALARM + 1));
    wait_done(n);
    wait_ack(a, n);
    check("t4_third",   128'(a), 128'(3'b001));
    check("t4_met_lat", 128'(n), 128'(HOLD_RX + 1));
    wait_done(n);

    // 5. stale lcd_done ignored; unresponsive driver times out
    drv_mode = 1;
    repeat (2) @(negedge clk);
    raise(2, rnd128(), rnd128());
    wait_ack(a, n);
    repeat (10) @(negedge clk);
    check("t5_stale_busy", 128'(o_busy), 128'(1));
    drv_mode = 0;
    wait_done(n);
    drv_mode = 2;
    raise(2, rnd128(), rnd128());
    wait_ack(a, n);
    wait_tmo(n);
    check("t5_tmo_lat",   128'(n), 128'(WR_TIMEOUT));
    check("t5_tmo_en",    128'(o_lcd_en), 128'(0));
    check("t5_tmo_owner", 128'(o_owner), 128'(2));
    drv_mode = 0;

    // 6. asynchronous reset in the middle of a write
    raise(1, rnd128(), rnd128());
    wait_ack(a, n);
    check("t6_rx_ack", 128'(a), 128'(3'b010));
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6_en",    128'(o_lcd_en), 128'(0));
    check("t6_owner", 128'(o_owner),  128'(3));
    check("t6_row1",  o_lcd_row1,     BAN1);
    check("t6_busy",  128'(o_busy),   128'(0));
    @(negedge clk);
    r_req = '0;
    rst_n = 1'b1;

    // random traffic
    repeat (4000) begin
      @(negedge clk);
      rand_drive();
    end
    r_req = '0;
    drv_mode = 0;
    repeat (100) @(negedge clk);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
